// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard for in-order issue.
// x0 is hardwired to zero. Reads are combinational, with optional write-to-read forwarding.
module regfile_scoreboard #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned BYPASS    = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_RD-1:0][$clog2(REG_COUNT)-1:0]   rd_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]                rd_data,
    output logic [NUM_RD-1:0]                          rd_busy,
    input  logic                                       wr_en,
    input  logic [$clog2(REG_COUNT)-1:0]               wr_addr,
    input  logic [XLEN-1:0]                            wr_data,
    input  logic                                       rsv_en,
    input  logic [$clog2(REG_COUNT)-1:0]               rsv_addr,
    input  logic                                       flush,
    output logic [$clog2(REG_COUNT):0]                 busy_cnt
);

    localparam int unsigned AW  = $clog2(REG_COUNT);
    localparam bit          BYP = (BYPASS != 0);

    logic [XLEN-1:0]      regs_q [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;
    logic [AW:0]          cnt_q;
    logic [AW:0]          cnt_d;

    logic wr_ok;
    assign wr_ok = wr_en && (wr_addr != '0);

    // Entry 0 is cleared by reset and never written, so it always reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < REG_COUNT; k++) begin
                regs_q[k] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Busy update priority: flush > new reservation > completing write.
    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                logic rsv_hit;
                logic wr_hit;
                assign rsv_hit    = rsv_en && (rsv_addr == AW'(gi));
                assign wr_hit     = wr_en && (wr_addr == AW'(gi));
                assign busy_d[gi] = flush   ? 1'b0 :
                                    rsv_hit ? 1'b1 :
                                    wr_hit  ? 1'b0 : busy_q[gi];
            end
        end
    endgenerate

    always_comb begin
        cnt_d = '0;
        for (int k = 0; k < REG_COUNT; k++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    // A forwarded write also means the producer has completed this cycle.
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic fwd;
            assign fwd         = BYP && wr_ok && (wr_addr == rd_addr[gi]);
            assign rd_data[gi] = fwd ? wr_data : regs_q[rd_addr[gi]];
            assign rd_busy[gi] = fwd ? 1'b0    : busy_q[rd_addr[gi]];
        end
    endgenerate

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width in bits.
REQ-002 SHALL have parameter REG_COUNT, default 32, number of architectural registers (power of 2, >= 2).
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (>= 1).
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have ports: clk  in  1  rising-edge clock (single clock domain).
REQ-006 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: rd_addr  in  NUM_RD x clog2(REG_COUNT)  read addresses.
REQ-008 SHALL have ports: rd_data  out  NUM_RD x XLEN  read data.
REQ-009 SHALL have ports: rd_busy  out  NUM_RD  addressed register has pending producer.
REQ-010 SHALL have ports: wr_en  in  1  write strobe; wr_addr  in  clog2(REG_COUNT)  destination; wr_data  in  XLEN  write value.
REQ-011 SHALL have ports: rsv_en  in  1  reserve destination; rsv_addr  in  clog2(REG_COUNT)  register to mark busy.
REQ-012 SHALL have ports: flush  in  1  discard all reservations.
REQ-013 SHALL have ports: busy_cnt  out  clog2(REG_COUNT)+1  number of busy registers.

Function
REQ-014 Register 0 SHALL read as zero on every port and SHALL ignore writes and reservations.
REQ-015 Writes SHALL occur only at rising clk when wr_en=1 and wr_addr!=0; no latch or combinational storage.
REQ-016 Reads SHALL be combinational, zero latency; rd_data[i] = regs[rd_addr[i]] as of last edge.
REQ-017 With BYPASS=1, wr_en=1 and wr_addr==rd_addr[i]!=0 SHALL make rd_data[i]=wr_data in the same cycle.
REQ-018 With BYPASS=0, the written value SHALL first appear on rd_data the cycle after the write edge.
REQ-019 Scoreboard: one busy bit per register; busy[0] SHALL be constant 0.
REQ-020 At an edge, wr_en with wr_addr!=0 SHALL clear busy[wr_addr].
REQ-021 At an edge, rsv_en with rsv_addr!=0 SHALL set busy[rsv_addr].
REQ-022 rsv and wr to the same address in one cycle SHALL leave busy set (new producer wins); data still written.
REQ-023 flush=1 SHALL clear all busy bits at the edge; flush SHALL override a same-cycle rsv_en; a same-cycle write SHALL still update data.
REQ-024 rd_busy[i] SHALL equal busy[rd_addr[i]]; with BYPASS=1, rd_busy[i] SHALL be 0 when a same-cycle write targets rd_addr[i]!=0 and no same-address... (resolved): forwarding clears rd_busy[i] for that cycle.
REQ-025 busy_cnt SHALL be a registered population count of busy bits, updated at the same edge as the bits; range 0..REG_COUNT-1.
REQ-026 Multiple read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-027 rst=1 at an edge SHALL clear all registers to 0, all busy bits to 0, busy_cnt to 0.
REQ-028 rst SHALL take priority over wr_en, rsv_en and flush in the same cycle.
REQ-029 Reset mid-operation SHALL drop all pending reservations; no write from the reset cycle SHALL persist.
REQ-030 Outputs after reset: rd_data all 0, rd_busy all 0, busy_cnt 0.

Verification
REQ-031 Write x5=0xDEADBEEF, next cycle read x5 on both ports -> rd_data=0xDEADBEEF on both.
REQ-032 Write x0=0xFFFFFFFF, rsv x0 -> rd_data for x0 = 0, rd_busy=0, busy_cnt=0.
REQ-033 BYPASS=1: wr x7=0x12345678 while reading x7 same cycle -> rd_data=0x12345678, rd_busy=0; BYPASS=0 -> old value, then new value next cycle.
REQ-034 rsv x3, rsv x4 (busy_cnt=2), then rsv x3 + wr x3 same cycle -> x3 stays busy, busy_cnt=2; then wr x4 -> busy_cnt=1.
REQ-035 rsv x1..x10 then flush with rsv x11 same cycle -> all rd_busy=0, busy_cnt=0; data unchanged.
REQ-036 Load x1..x31 nonzero, rsv x9, assert rst with wr_en=1 -> all reads 0, busy_cnt=0 next cycle.
